// File: rtl/nn_pkg.sv
// nn_pkg: widths shared across the training datapath and the sample-buffer state encoding.
package nn_pkg;
    localparam int NN_X_W = 4;
    localparam int NN_T_W = 4;
    typedef enum logic [1:0] {
        SB_EMPTY   = 2'd0,
        SB_LOADING = 2'd1,
        SB_RUN     = 2'd2,
        SB_DONE    = 2'd3
    } sbuf_state_t;
endpackage

// File: rtl/pin_strobe_sync.sv
// pin_strobe_sync: two-flop synchronizer for an asynchronous pin plus a one-cycle rising-edge pulse.
module pin_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stb
);
    logic [2:0] sh;
    always_ff @(posedge clk or posedge rst)
        if (rst) sh <= '0;
        else sh <= {sh[1:0], pin};
    assign stb = sh[1] & ~sh[2];
endmodule

// File: rtl/training_sample_buffer.sv
// training_sample_buffer: stores training samples and replays them one per backprop pass, epoch after epoch.
// Optional epoch limit / DONE state is built when SAMPLE_BUF_EPOCH_LIMIT_EN is defined.
module training_sample_buffer
    import nn_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int X_W        = NN_X_W,
    parameter int T_W        = NN_T_W,
    parameter int EPOCH_W    = 8,
    parameter int MAX_EPOCHS = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     load_i,
    input  logic [X_W-1:0]           x_wr_i,
    input  logic [T_W-1:0]           t_wr_i,
    input  logic                     start_i,
    input  logic                     next_i,
    input  logic                     clear_i,
    output logic [X_W-1:0]           x_o,
    output logic [T_W-1:0]           target_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic [EPOCH_W-1:0]       epoch_o,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic                     done_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    sbuf_state_t state, state_n;
    logic [CW-1:0] count, count_n;
    logic [AW-1:0] idx, idx_n;
    logic [EPOCH_W-1:0] epoch, epoch_n, epoch_inc;
    logic ovf, ovf_n, wr_stb, wr_en, wrap;
    logic [X_W+T_W-1:0] mem [DEPTH];

    pin_strobe_sync u_load_sync (
        .clk (clk_i),
        .rst (rst_i),
        .pin (load_i),
        .stb (wr_stb)
    );

    assign wrap      = CW'(idx) + CW'(1) == count;
    assign epoch_inc = &epoch ? epoch : epoch + 1'b1;

    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = idx;
        epoch_n = epoch;
        ovf_n   = ovf;
        wr_en   = 1'b0;
        if (clear_i) begin
            state_n = SB_EMPTY;
            count_n = '0;
            idx_n   = '0;
            epoch_n = '0;
            ovf_n   = 1'b0;
        end else begin
            case (state)
                SB_EMPTY: if (wr_stb) begin
                    wr_en   = 1'b1;
                    count_n = CW'(1);
                    state_n = SB_LOADING;
                end
                SB_LOADING: if (start_i) begin
                    state_n = SB_RUN;
                    idx_n   = '0;
                end else if (wr_stb) begin
                    wr_en   = count != CW'(DEPTH);
                    count_n = wr_en ? count + 1'b1 : count;
                    ovf_n   = ovf | ~wr_en;
                end
                SB_RUN: if (next_i) begin
                    idx_n   = wrap ? '0 : idx + 1'b1;
                    epoch_n = wrap ? epoch_inc : epoch;
`ifdef SAMPLE_BUF_EPOCH_LIMIT_EN
                    if (wrap && epoch_inc == EPOCH_W'(MAX_EPOCHS)) state_n = SB_DONE;
`endif
                end
                default: ;
            endcase
        end
    end

    // Sample storage is frozen outside LOADING/EMPTY, so no reset is needed.
    always_ff @(posedge clk_i)
        if (en_i && wr_en) mem[count[AW-1:0]] <= {x_wr_i, t_wr_i};

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state    <= SB_EMPTY;
            count    <= '0;
            idx      <= '0;
            epoch    <= '0;
            ovf      <= 1'b0;
            valid_o  <= 1'b0;
            x_o      <= '0;
            target_o <= '0;
        end else if (en_i) begin
            state   <= state_n;
            count   <= count_n;
            idx     <= idx_n;
            epoch   <= epoch_n;
            ovf     <= ovf_n;
            valid_o <= state == SB_RUN && state_n == SB_RUN;
            // Registered read: the presented sample lags the index by one cycle.
            if (state_n == SB_EMPTY) {x_o, target_o} <= '0;
            else if (state == SB_RUN) {x_o, target_o} <= mem[idx];
        end

    assign count_o    = count;
    assign idx_o      = idx;
    assign epoch_o    = epoch;
    assign full_o     = count == CW'(DEPTH);
    assign overflow_o = ovf;
`ifdef SAMPLE_BUF_EPOCH_LIMIT_EN
    assign done_o = state == SB_DONE;
`else
    logic unused_max;
    assign unused_max = MAX_EPOCHS[0];
    assign done_o     = 1'b0;
`endif
endmodule

// File: tb/tb_training_sample_buffer.sv
// tb_training_sample_buffer: directed scoreboard bench for training_sample_buffer (DEPTH=8, MAX_EPOCHS=2).
module tb_training_sample_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic load = 1'b0;
    logic [3:0] x_wr = '0;
    logic [3:0] t_wr = '0;
    logic start = 1'b0;
    logic next = 1'b0;
    logic clear = 1'b0;
    logic [3:0] x_o, target_o;
    logic valid_o, full_o, overflow_o, done_o;
    logic [3:0] count_o;
    logic [2:0] idx_o;
    logic [7:0] epoch_o;
    int n_cmp = 0;
    int n_mis = 0;
    string tag_q[$];
    logic [31:0] exp_q[$];

    training_sample_buffer #(.DEPTH(8), .X_W(4), .T_W(4), .EPOCH_W(8), .MAX_EPOCHS(2)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .x_wr_i(x_wr), .t_wr_i(t_wr),
        .start_i(start), .next_i(next), .clear_i(clear), .x_o(x_o), .target_o(target_o),
        .valid_o(valid_o), .count_o(count_o), .idx_o(idx_o), .epoch_o(epoch_o),
        .full_o(full_o), .overflow_o(overflow_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic load_sample(input logic [3:0] xv, input logic [3:0] tv);
        x_wr = xv;
        t_wr = tv;
        load = 1'b1;
        repeat (3) tick();
        load = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_next();
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        int seq[7] = '{1, 2, 0, 1, 2, 0, 1};
        tick();
        expect_v("rst_count", 0); chk(32'(count_o));
        expect_v("rst_valid", 0); chk(32'(valid_o));
        expect_v("rst_x", 0);     chk(32'(x_o));
        expect_v("rst_epoch", 0); chk(32'(epoch_o));
        expect_v("rst_flags", 0); chk({full_o, overflow_o, done_o});
        rst = 1'b0;
        tick();
        expect_v("load3_count", 3);
        expect_v("start_valid", 1);
        expect_v("start_x", 3);
        expect_v("start_t", 9);
        load_sample(4'h3, 4'h9);
        load_sample(4'h5, 4'h2);
        load_sample(4'hA, 4'hF);
        chk(32'(count_o));
        pulse_start();
        chk(32'(valid_o));
        chk(32'(x_o));
        chk(32'(target_o));
        for (int i = 0; i < 7; i++) begin
            expect_v($sformatf("idx_seq%0d", i), 32'(seq[i]));
            pulse_next();
            chk(32'(idx_o));
            tick();
        end
        expect_v("epoch_after7", 2); chk(32'(epoch_o));
        expect_v("x_idx1", 5);       chk(32'(x_o));
        expect_v("t_idx1", 2);       chk(32'(target_o));
        expect_v("en_off_idx", 1);
        expect_v("en_off_epoch", 2);
        en = 1'b0;
        pulse_next();
        en = 1'b1;
        chk(32'(idx_o));
        chk(32'(epoch_o));
        expect_v("clr_count", 0);
        expect_v("clr_epoch", 0);
        expect_v("clr_valid", 0);
        expect_v("clr_x", 0);
        clear = 1'b1;
        next = 1'b1;
        tick();
        clear = 1'b0;
        next = 1'b0;
        chk(32'(count_o));
        chk(32'(epoch_o));
        chk(32'(valid_o));
        chk(32'(x_o));
        expect_v("fill_count", 8);
        expect_v("fill_full", 1);
        expect_v("fill_ovf", 1);
        for (int i = 0; i < 9; i++) load_sample(4'(i), 4'(15 - i));
        chk(32'(count_o));
        chk(32'(full_o));
        chk(32'(overflow_o));
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            pulse_next();
            tick();
        end
        expect_v("slot7_idx", 7); chk(32'(idx_o));
        expect_v("slot7_x", 7);   chk(32'(x_o));
        expect_v("slot7_t", 8);   chk(32'(target_o));
        expect_v("arst_count", 0);
        expect_v("arst_valid", 0);
        expect_v("arst_x", 0);
        expect_v("arst_idx", 0);
        expect_v("arst_flags", 0);
        rst = 1'b1;
        #1;
        chk(32'(count_o));
        chk(32'(valid_o));
        chk(32'(x_o));
        chk(32'(idx_o));
        chk({full_o, overflow_o, done_o});
        rst = 1'b0;
        tick();
        load_sample(4'h6, 4'h1);
        pulse_start();
        expect_v("one_epoch1", 1);
        pulse_next();
        chk(32'(epoch_o));
        tick();
`ifdef SAMPLE_BUF_EPOCH_LIMIT_EN
        expect_v("lim_done", 1);
        expect_v("lim_valid", 0);
        expect_v("lim_epoch", 2);
        expect_v("lim_hold_epoch", 2);
        expect_v("lim_hold_done", 1);
        pulse_next();
        chk(32'(done_o));
        chk(32'(valid_o));
        chk(32'(epoch_o));
        tick();
        pulse_next();
        chk(32'(epoch_o));
        chk(32'(done_o));
`else
        expect_v("nolim_done", 0);
        expect_v("nolim_valid", 1);
        expect_v("nolim_epoch", 2);
        expect_v("nolim_epoch3", 3);
        pulse_next();
        chk(32'(done_o));
        chk(32'(valid_o));
        chk(32'(epoch_o));
        tick();
        pulse_next();
        chk(32'(epoch_o));
`endif
        expect_v("one_x", 6); chk(32'(x_o));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
